// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the 16-core / 16-bank scheduler.
// Holds the sizing constants, the op encodings, the per-core FSM state
// encoding, the per-core address layout and the request decode helper.
package mem_arb_pkg;

   localparam int unsigned N_CORES   = 16;
   localparam int unsigned N_BANKS   = 16;
   localparam int unsigned CORE_ID_W = 4;
   localparam int unsigned BANK_ID_W = 4;
   localparam int unsigned WORD_W    = 8;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned BANK_LAT  = 1;
   localparam int unsigned CNT_W     = $clog2(BANK_LAT + 1);

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10
   } op_e;

   typedef enum logic {
      CORE_IDLE = 1'b0,
      CORE_WAIT = 1'b1
   } core_state_e;

   // Per-core address lane: bank select above word address.
   typedef struct packed {
      logic [BANK_ID_W-1:0] bank;
      logic [WORD_W-1:0]    word;
   } core_addr_t;

   // Request bit pair {wr, rd} to op; a simultaneous read+write is a write.
   function automatic op_e decode_op(input logic [1:0] en);
      op_e op;
      case (en)
         2'b01:   op = OP_RD;
         2'b10,
         2'b11:   op = OP_WR;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/bank_scheduler_rr_pick.sv
// Round-robin picker for one bank.
// Ports:
//   req         in  N_CORES    eligible cores for this bank
//   ptr         in  CORE_ID_W  last granted core; search starts at ptr+1
//   grant_id    out CORE_ID_W  chosen core (0 when none)
//   grant_valid out 1          a core was chosen
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [N_CORES-1:0]   req,
   input  logic [CORE_ID_W-1:0] ptr,
   output logic [CORE_ID_W-1:0] grant_id,
   output logic                 grant_valid
);

   logic [CORE_ID_W-1:0] idx;

   // Scan ptr+1 .. ptr+16 (mod 16); the first hit wins, ptr itself is last.
   always_comb begin
      grant_id    = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int unsigned k = 1; k <= N_CORES; k++) begin
         idx = ptr + CORE_ID_W'(k);
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/bank_scheduler.sv
// Conflict-aware scheduler between 16 cores and 16 shared memory banks.
// Every bank grants one eligible core per cycle by its own round-robin
// pointer; granted cores wait BANK_LAT cycles for bank data, capture it
// and emit a one-cycle val pulse.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   enable        per core {wr, rd} request bits, held until val
//   addr          per core {bank[3:0], word[7:0]}
//   wr_data       per core write byte
//   rd_data       per core read byte, updated for reads at completion
//   val           per core completion pulse
//   bank_addr     per bank word address (combinational, grant cycle)
//   bank_wr_data  per bank write byte (combinational, grant cycle)
//   bank_rd_en    per bank read strobe (combinational, grant cycle)
//   bank_wr_en    per bank write strobe (combinational, grant cycle)
//   bank_rd_data  per bank data_out, valid BANK_LAT cycles after strobe
module bank_scheduler
   import mem_arb_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [2*N_CORES-1:0]        enable,
   input  logic [ADDR_W*N_CORES-1:0]   addr,
   input  logic [DATA_W*N_CORES-1:0]   wr_data,
   output logic [DATA_W*N_CORES-1:0]   rd_data,
   output logic [N_CORES-1:0]          val,
   output logic [WORD_W*N_BANKS-1:0]   bank_addr,
   output logic [DATA_W*N_BANKS-1:0]   bank_wr_data,
   output logic [N_BANKS-1:0]          bank_rd_en,
   output logic [N_BANKS-1:0]          bank_wr_en,
   input  logic [DATA_W*N_BANKS-1:0]   bank_rd_data
);

   op_e                   core_op    [N_CORES];
   core_addr_t            core_addr  [N_CORES];
   logic [DATA_W-1:0]     core_wdata [N_CORES];

   core_state_e           state_q    [N_CORES];
   core_state_e           state_d    [N_CORES];
   logic [CNT_W-1:0]      cnt_q      [N_CORES];
   logic [CNT_W-1:0]      cnt_d      [N_CORES];
   logic [BANK_ID_W-1:0]  bank_q     [N_CORES];
   op_e                   op_q       [N_CORES];

   logic [N_BANKS-1:0][N_CORES-1:0] elig;
   logic [CORE_ID_W-1:0]  ptr_q      [N_BANKS];
   logic [CORE_ID_W-1:0]  grant_id   [N_BANKS];
   logic [N_BANKS-1:0]    grant_valid;
   logic [N_CORES-1:0]    core_gnt;
   logic [N_CORES-1:0]    capture;

   // Unpack per-core request lanes.
   always_comb begin
      for (int unsigned c = 0; c < N_CORES; c++) begin
         core_op[c]    = decode_op(enable[2*c +: 2]);
         core_addr[c]  = core_addr_t'(addr[ADDR_W*c +: ADDR_W]);
         core_wdata[c] = wr_data[DATA_W*c +: DATA_W];
      end
   end

   // Eligibility matrix; reset suppresses all grants in the reset cycle.
   always_comb begin
      elig = '0;
      for (int unsigned b = 0; b < N_BANKS; b++) begin
         for (int unsigned c = 0; c < N_CORES; c++) begin
            elig[b][c] = !reset && (state_q[c] == CORE_IDLE) &&
                         (core_op[c] != OP_NONE) &&
                         (core_addr[c].bank == BANK_ID_W'(b));
         end
      end
   end

   for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_bank
      rr_pick u_pick (
         .req         (elig[gb]),
         .ptr         (ptr_q[gb]),
         .grant_id    (grant_id[gb]),
         .grant_valid (grant_valid[gb])
      );
   end

   // Route each bank's granted core onto its strobes, address and data.
   always_comb begin
      bank_rd_en   = '0;
      bank_wr_en   = '0;
      bank_addr    = '0;
      bank_wr_data = '0;
      for (int unsigned b = 0; b < N_BANKS; b++) begin
         if (grant_valid[b]) begin
            bank_rd_en[b] = (core_op[grant_id[b]] == OP_RD);
            bank_wr_en[b] = (core_op[grant_id[b]] == OP_WR);
            bank_addr[WORD_W*b +: WORD_W]    = core_addr[grant_id[b]].word;
            bank_wr_data[DATA_W*b +: DATA_W] = core_wdata[grant_id[b]];
         end
      end
   end

   // A core sits in at most one bank's request vector, so grants are disjoint.
   always_comb begin
      core_gnt = '0;
      for (int unsigned b = 0; b < N_BANKS; b++) begin
         if (grant_valid[b]) core_gnt[grant_id[b]] = 1'b1;
      end
   end

   // Per-core FSM state register, plus bank/op latched at grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < N_CORES; c++) begin
            state_q[c] <= CORE_IDLE;
            cnt_q[c]   <= '0;
            bank_q[c]  <= '0;
            op_q[c]    <= OP_NONE;
         end
      end else begin
         for (int unsigned c = 0; c < N_CORES; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
            if (core_gnt[c]) begin
               bank_q[c] <= core_addr[c].bank;
               op_q[c]   <= core_op[c];
            end
         end
      end
   end

   // Per-core next state: countdown from BANK_LAT, one extra WAIT cycle
   // with count 0 is the val cycle.
   always_comb begin
      for (int unsigned c = 0; c < N_CORES; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         case (state_q[c])
            CORE_IDLE: begin
               if (core_gnt[c]) begin
                  state_d[c] = CORE_WAIT;
                  cnt_d[c]   = CNT_W'(BANK_LAT);
               end
            end
            CORE_WAIT: begin
               if (cnt_q[c] == '0) state_d[c] = CORE_IDLE;
               else                cnt_d[c]   = cnt_q[c] - CNT_W'(1);
            end
            default: state_d[c] = CORE_IDLE;
         endcase
      end
   end

   // Per-core output decode: bank data is valid in the last countdown cycle.
   always_comb begin
      capture = '0;
      for (int unsigned c = 0; c < N_CORES; c++) begin
         capture[c] = (state_q[c] == CORE_WAIT) && (cnt_q[c] == CNT_W'(1));
      end
   end

   // Completion pulse and read data capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         val     <= '0;
         rd_data <= '0;
      end else begin
         val <= capture;
         for (int unsigned c = 0; c < N_CORES; c++) begin
            if (capture[c] && (op_q[c] == OP_RD))
               rd_data[DATA_W*c +: DATA_W] <= bank_rd_data[DATA_W*bank_q[c] +: DATA_W];
         end
      end
   end

   // Round-robin pointers; unchanged on idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned b = 0; b < N_BANKS; b++) ptr_q[b] <= CORE_ID_W'(N_CORES - 1);
      end else begin
         for (int unsigned b = 0; b < N_BANKS; b++) begin
            if (grant_valid[b]) ptr_q[b] <= grant_id[b];
         end
      end
   end

endmodule
